clock_alarm_core: RTL

//  24-hour BCD time-of-day keeper with field-by-field setting, N independent alarms and a
//  4-digit display mux. Owns its 1 Hz prescaler, so no external divider block is needed.

---
 rtl/clock_alarm_core.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/clock_alarm_core.sv
// ---------------------------------------------------------------------------
// clock_alarm_core
//
// Purpose:
//   24-hour BCD time-of-day keeper with its own 1 Hz prescaler, field-by-field
//   time setting, N_ALARM independent alarm channels and a 4-digit display mux.
//   Takes short/long button pulses from the debouncer and feeds BCD digits to
//   the 7-segment driver.
//
// Build option:
//   SNOOZE_EN  - when defined, b1_short during a ring snoozes it for
//                SNOOZE_MIN minutes instead of simply dismissing it.
//
// Parameters:
//   TICK_DIV    clk cycles per second (>= 2)
//   N_ALARM     number of alarm channels (1..8)
//   SNOOZE_MIN  snooze length in minutes (1..59), used with SNOOZE_EN
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   en                    block selected; low forces RUN and ignores buttons
//   b0_long / b0_short    enter-exit SET / dismiss ring
//   b1_long / b1_short    increment field / next field or toggle seconds view
//   alarm_time, alarm_on  per-channel {h1,h0,m1,m0} BCD and enable
//   digit3..digit0        BCD display digits, 4'hF = blank
//   setting, field        SET indicator and selected field (00 h, 01 m, 10 s)
//   show_sec              RUN view select ("--ss" when 1)
//   tick                  1-cycle pulse on each second increment
//   ring, ring_idx        alarm ringing and lowest matching channel
// ---------------------------------------------------------------------------
module clock_alarm_core #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int N_ALARM    = 2,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    b0_long,
  input  logic                    b0_short,
  input  logic                    b1_long,
  input  logic                    b1_short,
  input  logic [16*N_ALARM-1:0]   alarm_time,
  input  logic [N_ALARM-1:0]      alarm_on,
  output logic [3:0]              digit3,
  output logic [3:0]              digit2,
  output logic [3:0]              digit1,
  output logic [3:0]              digit0,
  output logic                    setting,
  output logic [1:0]              field,
  output logic                    show_sec,
  output logic                    tick,
  output logic                    ring,
  output logic [2:0]              ring_idx
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] SET_H = 2'd1;
  localparam logic [1:0] SET_M = 2'd2;
  localparam logic [1:0] SET_S = 2'd3;

  // Elaboration-time range check on the parameters.
  generate
    if (TICK_DIV < 2 || N_ALARM < 1 || N_ALARM > 8 || SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_params
      $error("clock_alarm_core: parameter out of range");
    end
  endgenerate

  // Two-digit BCD increment that wraps to 00 after 'last'.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic [7:0]    hh;
  logic [7:0]    mm;
  logic [7:0]    ss;
  logic [5:0]    ring_cnt;

  logic          run;
  logic          go_set;
  logic          go_run;
  logic          set_btn;
  logic          run_btn;
  logic          wrap;
  logic          ring_stop;
  logic          alarm_hit;
  logic          hhmm_view;
  logic [N_ALARM-1:0] match;
  logic [2:0]    match_idx;
  logic          snooze_fire;
  logic [2:0]    snooze_idx;

  assign run     = (state == RUN);
  assign go_set  = run && en && b0_long;
  assign go_run  = !run && (!en || b0_long);
  // Button cycles that are not swallowed by a b0_long in the same cycle.
  assign set_btn = !run && en && !b0_long;
  assign run_btn = run && en && !b0_long;
  // The prescaler is frozen in SET and also in the cycle that enters SET.
  assign wrap    = run && !go_set && (presc == PRESC_LAST);

  // ---------------- alarm compare ----------------
  genvar gi;
  generate
    for (gi = 0; gi < N_ALARM; gi++) begin : g_ch
      assign match[gi] = alarm_on[gi] && (alarm_time[16*gi +: 16] == {hh, mm});
    end
  endgenerate

  always_comb begin
    match_idx = 3'd0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (match[i]) match_idx = 3'(i);
    end
  end

  // tick is only ever high in RUN, so this fires on the second that rolled to :00.
  assign alarm_hit = run && tick && (ss == 8'h00) && (|match);
  assign ring_stop = run_btn && (b0_short || b1_short);

  // ---------------- prescaler and tick ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= wrap;
      if (!run || go_set || wrap)
        presc <= '0;
      else
        presc <= presc + PW'(1);
    end
  end

  // ---------------- time of day ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hh <= 8'h00;
      mm <= 8'h00;
      ss <= 8'h00;
    end else if (wrap) begin
      ss <= bcd_inc(ss, 8'h59);
      if (ss == 8'h59) begin
        mm <= bcd_inc(mm, 8'h59);
        if (mm == 8'h59) hh <= bcd_inc(hh, 8'h23);
      end
    end else if (set_btn && b1_long) begin
      // Field edits wrap inside the field; no carry into neighbours.
      case (state)
        SET_H:   hh <= bcd_inc(hh, 8'h23);
        SET_M:   mm <= bcd_inc(mm, 8'h59);
        SET_S:   ss <= bcd_inc(ss, 8'h59);
        default: ;
      endcase
    end
  end

  // ---------------- mode FSM and view ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      show_sec <= 1'b0;
    end else begin
      if (go_set)
        state <= SET_H;
      else if (go_run)
        state <= RUN;
      else if (set_btn && b1_short)
        state <= (state == SET_S) ? SET_H : state + 2'd1;

      if (go_set)
        show_sec <= 1'b0;
      else if (run_btn && b1_short && !ring)
        show_sec <= !show_sec;
    end
  end

  // ---------------- ring ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring     <= 1'b0;
      ring_idx <= 3'd0;
      ring_cnt <= 6'd0;
    end else if (go_set) begin
      ring     <= 1'b0;
      ring_idx <= 3'd0;
    end else if (ring) begin
      // New matches are ignored while ringing.
      if (ring_stop) begin
        ring     <= 1'b0;
        ring_idx <= 3'd0;
      end else if (tick) begin
        if (ring_cnt == 6'd59) begin
          ring     <= 1'b0;
          ring_idx <= 3'd0;
        end else begin
          ring_cnt <= ring_cnt + 6'd1;
        end
      end
    end else if (snooze_fire) begin
      ring     <= 1'b1;
      ring_idx <= snooze_idx;
      ring_cnt <= 6'd0;
    end else if (alarm_hit) begin
      ring     <= 1'b1;
      ring_idx <= match_idx;
      ring_cnt <= 6'd0;
    end
  end

  // ---------------- snooze ----------------
`ifdef SNOOZE_EN
  localparam logic [11:0] SNOOZE_LAST = 12'(SNOOZE_MIN * 60 - 1);

  logic        snooze_act;
  logic [11:0] snooze_cnt;
  logic        snooze_cancel;
  logic        snooze_arm;

  assign snooze_cancel = go_set || (run_btn && b0_short);
  assign snooze_arm    = run_btn && ring && b1_short && !b0_short;
  // If a ring is already active on expiry the snooze is simply consumed.
  assign snooze_fire   = snooze_act && tick && (snooze_cnt == SNOOZE_LAST) && !snooze_cancel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snooze_act <= 1'b0;
      snooze_cnt <= 12'd0;
      snooze_idx <= 3'd0;
    end else if (snooze_cancel) begin
      snooze_act <= 1'b0;
    end else if (snooze_arm) begin
      snooze_act <= 1'b1;
      snooze_cnt <= 12'd0;
      snooze_idx <= ring_idx;
    end else if (snooze_act && tick) begin
      if (snooze_cnt == SNOOZE_LAST)
        snooze_act <= 1'b0;
      else
        snooze_cnt <= snooze_cnt + 12'd1;
    end
  end
`else
  assign snooze_fire = 1'b0;
  assign snooze_idx  = 3'd0;
`endif

  // ---------------- outputs ----------------
  assign setting   = !run;
  assign field     = run ? 2'b00 : state - 2'd1;
  assign hhmm_view = (state == SET_H) || (state == SET_M) || (run && !show_sec);
  assign digit3    = hhmm_view ? hh[7:4] : 4'hF;
  assign digit2    = hhmm_view ? hh[3:0] : 4'hF;
  assign digit1    = hhmm_view ? mm[7:4] : ss[7:4];
  assign digit0    = hhmm_view ? mm[3:0] : ss[3:0];

endmodule
